alu_arbiter: RTL

//  Shares one combinational ALU between two requesters (e.g. the main datapath and an address/branch helper).
//  - Round-robin arbitration.
//  - Operands are registered, then the ALU runs, then the result is registered.
//  - The result is held until the winning requester accepts it.
//  - Sits between the requesters and the ALU instance. It owns the ALU's operand/control inputs exclusively.

---
 rtl/alu_arbiter_if.sv | 55 +++++
 rtl/alu_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles every signal between two requesters, the shared ALU and the
//   alu_arbiter block.
//   master : requester / ALU side (drives requests, response accepts, ALU result)
//   slave  : alu_arbiter side (drives request accepts, responses, ALU operands)
//   Signals:
//     req0_*/req1_*  : valid, ready, op1, op2, ctrl per requester
//     rsp_valid[1:0] : per-requester result valid, rsp_ready[1:0] per-requester accept
//     rsp_data/zero/err : shared result, qualified by rsp_valid
//     alu_op1/op2/ctrl  : to ALU, alu_out/alu_zero : from ALU
interface alu_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [WIDTH-1:0]  req0_op1;
  logic [WIDTH-1:0]  req0_op2;
  logic [CTRL_W-1:0] req0_ctrl;
  logic              req1_valid;
  logic              req1_ready;
  logic [WIDTH-1:0]  req1_op1;
  logic [WIDTH-1:0]  req1_op2;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_zero;
  logic              rsp_err;
  logic [WIDTH-1:0]  alu_op1;
  logic [WIDTH-1:0]  alu_op2;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_zero;

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_ctrl,
    output req1_valid, req1_op1, req1_op2, req1_ctrl,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_zero, rsp_err,
    output rsp_ready,
    input  alu_op1, alu_op2, alu_ctrl,
    output alu_out, alu_zero
  );

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_ctrl,
    input  req1_valid, req1_op1, req1_op2, req1_ctrl,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_zero, rsp_err,
    input  rsp_ready,
    output alu_op1, alu_op2, alu_ctrl,
    input  alu_out, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. A request is
//   accepted in IDLE (operands latched), the ALU is evaluated in EXEC
//   (result captured), and the result is held in RESP until the winning
//   requester accepts it. One operation per three cycles at best.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : alu_arbiter_if.slave (requests, responses, ALU operand/result)
//   Configuration macro ALU_ARB_FIXED_PRIO_EN:
//     defined   -> port 0 always wins a tie
//     undefined -> round-robin on ties (last_grant resets to 1, so port 0 wins first)
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input logic        clk,
  input logic        rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              grant_s;
  logic              any_valid_s;
  logic              req0_ready_s;
  logic              req1_ready_s;
  logic              grant_r;
  logic [WIDTH-1:0]  op1_r;
  logic [WIDTH-1:0]  op2_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [1:0]        rsp_valid_r;
  logic [WIDTH-1:0]  data_r;
  logic              zero_r;
  logic              err_r;

  // ALU control codes are defined as 4-bit patterns; anything else is reported as an error
  function automatic logic is_legal_ctrl(input logic [CTRL_W-1:0] code);
    logic legal;
    case (code)
      4'b0000, 4'b1001, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
    return legal;
  endfunction

  assign any_valid_s = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: port 1 only wins when port 0 is not asking
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid) begin
      grant_s = 1'b0;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end
`else
  logic last_grant_r;

  // Round-robin: on a tie the port that was not served last wins
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // last_grant only moves once a response has been accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (state_r == ST_RESP && bus.rsp_ready[grant_r]) begin
      last_grant_r <= grant_r;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and combinational request accept (IDLE only)
  always_comb begin
    state_s      = state_r;
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_s      = ST_EXEC;
          req0_ready_s = ~grant_s;
          req1_ready_s = grant_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: begin
        // the accept bit of the non-granted port has no effect
        if (bus.rsp_ready[grant_r]) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand latch, result capture and response valid
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r     <= 1'b0;
      op1_r       <= {WIDTH{1'b0}};
      op2_r       <= {WIDTH{1'b0}};
      ctrl_r      <= {CTRL_W{1'b0}};
      rsp_valid_r <= 2'b00;
      data_r      <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s) begin
            grant_r <= grant_s;
            op1_r   <= grant_s ? bus.req1_op1  : bus.req0_op1;
            op2_r   <= grant_s ? bus.req1_op2  : bus.req0_op2;
            ctrl_r  <= grant_s ? bus.req1_ctrl : bus.req0_ctrl;
          end
        end
        ST_EXEC: begin
          // an illegal code never lets the ALU output through
          if (is_legal_ctrl(ctrl_r)) begin
            data_r <= bus.alu_out;
            zero_r <= bus.alu_zero;
            err_r  <= 1'b0;
          end else begin
            data_r <= {WIDTH{1'b0}};
            zero_r <= 1'b0;
            err_r  <= 1'b1;
          end
          rsp_valid_r <= grant_r ? 2'b10 : 2'b01;
        end
        ST_RESP: begin
          if (bus.rsp_ready[grant_r]) begin
            rsp_valid_r <= 2'b00;
          end
        end
        default: begin
          rsp_valid_r <= 2'b00;
        end
      endcase
    end
  end

  // ALU inputs come straight from the latches so they stay quiet between operations
  assign bus.alu_op1    = op1_r;
  assign bus.alu_op2    = op2_r;
  assign bus.alu_ctrl   = ctrl_r;
  assign bus.req0_ready = req0_ready_s;
  assign bus.req1_ready = req1_ready_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_data   = data_r;
  assign bus.rsp_zero   = zero_r;
  assign bus.rsp_err    = err_r;

endmodule
